// File: rtl/lighthouse_scan_scheduler.sv
// Round-robin scheduler sharing one lighthouse peak-measurement unit across the sensor inputs:
// selects, settles, starts, waits for ready/timeout and emits one tagged result per measurement.
`default_nettype none

module lighthouse_scan_scheduler #(
  parameter int          NUM_SENSORS    = 16,
  parameter int          SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic [NUM_SENSORS-1:0]         sensor_mask_i,
  output logic [$clog2(NUM_SENSORS)-1:0] sensor_sel_o,
  output logic                           meas_start_o,
  input  logic                           meas_ready_i,
  input  logic [31:0]                    meas_duration_i,
  output logic                           result_valid_o,
  output logic [$clog2(NUM_SENSORS)-1:0] result_sensor_o,
  output logic [31:0]                    result_duration_o,
  output logic                           result_timeout_o,
  output logic                           busy_o,
  output logic [15:0]                    sweep_count_o
);

  localparam int          SEL_W       = $clog2(NUM_SENSORS);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        timer_q, timer_d;
  logic [SEL_W-1:0]   res_sensor_q, res_sensor_d;
  logic [31:0]        res_dur_q, res_dur_d;
  logic               res_to_q, res_to_d;
  logic [15:0]        sweep_q, sweep_d;

  logic [SEL_W-1:0]       pick;
  logic [NUM_SENSORS-1:0] above_sel;

  // Walk downward so the last hit is the first set bit at or after ptr (wrapping).
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (sensor_mask_i[ptr_q + SEL_W'(i)]) begin
        pick = ptr_q + SEL_W'(i);
      end
    end
  end

  // Bits strictly above the current sensor; empty for the last sensor.
  assign above_sel = {{(NUM_SENSORS-1){1'b1}}, 1'b0} << sel_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    res_sensor_d = res_sensor_q;
    res_dur_d    = res_dur_q;
    res_to_d     = res_to_q;
    sweep_d      = sweep_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i && (|sensor_mask_i)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (!(|sensor_mask_i)) begin
          state_d = S_IDLE;
        end else begin
          sel_d   = pick;
          cnt_d   = 8'd0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = S_START;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      S_START: begin
        // Timer holds the number of cycles elapsed since meas_start.
        timer_d = 32'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (meas_ready_i) begin
          res_sensor_d = sel_q;
          res_dur_d    = meas_duration_i;
          res_to_d     = 1'b0;
          state_d      = S_DONE;
        end else if (timer_q == TMO_LAST) begin
          res_sensor_d = sel_q;
          res_dur_d    = 32'd0;
          res_to_d     = 1'b1;
          state_d      = S_DONE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_DONE: begin
        ptr_d = sel_q + SEL_W'(1);
        if ((sensor_mask_i & above_sel) == '0) sweep_d = sweep_q + 16'd1;
        state_d = enable_i ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      res_sensor_q <= '0;
      res_dur_q    <= '0;
      res_to_q     <= 1'b0;
      sweep_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      res_sensor_q <= res_sensor_d;
      res_dur_q    <= res_dur_d;
      res_to_q     <= res_to_d;
      sweep_q      <= sweep_d;
    end
  end

  assign sensor_sel_o      = sel_q;
  assign meas_start_o      = (state_q == S_START);
  assign result_valid_o    = (state_q == S_DONE);
  assign result_sensor_o   = res_sensor_q;
  assign result_duration_o = res_dur_q;
  assign result_timeout_o  = res_to_q;
  assign busy_o            = (state_q != S_IDLE);
  assign sweep_count_o     = sweep_q;

endmodule

`default_nettype wire
